// File: rtl/stage_cfg_writer.sv
// Control-plane writer for one RMT stage: decodes AXI-Stream config packets
// and issues one single-cycle write to the offset RAM, the lookup CAM or the action RAM.
module stage_cfg_writer #(
    parameter int STAGE               = 0,
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int KEY_LEN             = 197,
    parameter int KEY_OFF             = 18,
    parameter int ACT_LEN             = 25,
    parameter int ADDR_WIDTH          = 4
) (
    input  logic                           axis_clk,
    input  logic                           aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] c_s_axis_tdata,
    input  logic                           c_s_axis_tvalid,
    input  logic                           c_s_axis_tlast,
    output logic                           c_s_axis_tready,
    output logic [KEY_OFF-1:0]             key_off_entry_out,
    output logic                           key_off_entry_valid,
    output logic [ADDR_WIDTH-1:0]          key_off_entry_addr,
    output logic [KEY_LEN-1:0]             lookup_din,
    output logic [KEY_LEN-1:0]             lookup_din_mask,
    output logic [ADDR_WIDTH-1:0]          lookup_din_addr,
    output logic                           lookup_din_en,
    output logic [ACT_LEN*25-1:0]          action_data_out,
    output logic [ADDR_WIDTH-1:0]          action_addr,
    output logic                           action_en,
    output logic [15:0]                    cfg_ok_cnt,
    output logic [15:0]                    cfg_err_cnt
);

    localparam int          DW       = C_S_AXIS_DATA_WIDTH;
    localparam int          ACT_W    = ACT_LEN * 25;
    localparam logic [3:0]  STAGE_ID = 4'(STAGE);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_ISSUE   = 2'd2;
    localparam logic [1:0] S_DROP    = 2'd3;

    localparam logic [1:0] T_OFF = 2'd0;
    localparam logic [1:0] T_CAM = 2'd1;
    localparam logic [1:0] T_ACT = 2'd2;
    localparam logic [1:0] T_RSV = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            r_type;
    logic [1:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DW-1:0]         r_pay0;
    logic [DW-1:0]         r_pay1;

    logic [KEY_OFF-1:0]    r_koff_data;
    logic [ADDR_WIDTH-1:0] r_koff_addr;
    logic                  r_koff_valid;
    logic [KEY_LEN-1:0]    r_key;
    logic [KEY_LEN-1:0]    r_mask;
    logic [ADDR_WIDTH-1:0] r_cam_addr;
    logic                  r_cam_en;
    logic [ACT_W-1:0]      r_act_data;
    logic [ADDR_WIDTH-1:0] r_act_addr;
    logic                  r_act_en;
    logic [15:0]           r_ok_cnt;
    logic [15:0]           r_err_cnt;

    logic                  w_accept;
    logic                  w_hdr_match;
    logic [1:0]            w_hdr_type;
    logic                  w_last_beat;
    logic [3*DW-1:0]       w_act_all;

    // tready is forced low while reset is held so nothing is accepted then
    assign c_s_axis_tready = aresetn && (r_state != S_ISSUE);
    assign w_accept        = c_s_axis_tvalid && c_s_axis_tready;
    assign w_hdr_match     = (c_s_axis_tdata[3:0] == STAGE_ID);
    assign w_hdr_type      = c_s_axis_tdata[5:4];
    // a packet of type t carries t+1 payload beats, so the last one arrives at cnt == t
    assign w_last_beat     = (r_cnt == r_type);
    assign w_act_all       = {c_s_axis_tdata, r_pay1, r_pay0};

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_type       <= T_OFF;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_pay0       <= '0;
            r_pay1       <= '0;
            r_koff_data  <= '0;
            r_koff_addr  <= '0;
            r_koff_valid <= 1'b0;
            r_key        <= '0;
            r_mask       <= '0;
            r_cam_addr   <= '0;
            r_cam_en     <= 1'b0;
            r_act_data   <= '0;
            r_act_addr   <= '0;
            r_act_en     <= 1'b0;
            r_ok_cnt     <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_koff_valid <= 1'b0;
            r_cam_en     <= 1'b0;
            r_act_en     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_type <= w_hdr_type;
                        r_addr <= c_s_axis_tdata[8 +: ADDR_WIDTH];
                        r_cnt  <= '0;
                        if (c_s_axis_tlast) begin
                            if (w_hdr_match) r_err_cnt <= satInc(r_err_cnt);
                        end else if (!w_hdr_match || w_hdr_type == T_RSV) begin
                            r_state <= S_DROP;
                            if (w_hdr_match) r_err_cnt <= satInc(r_err_cnt);
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        if (w_last_beat) begin
                            if (c_s_axis_tlast) begin
                                r_state <= S_ISSUE;
                                // the final beat is used straight from the bus, not from a slot
                                case (r_type)
                                    T_OFF: begin
                                        r_koff_data  <= c_s_axis_tdata[KEY_OFF-1:0];
                                        r_koff_addr  <= r_addr;
                                        r_koff_valid <= 1'b1;
                                    end
                                    T_CAM: begin
                                        r_key      <= r_pay0[KEY_LEN-1:0];
                                        r_mask     <= c_s_axis_tdata[KEY_LEN-1:0];
                                        r_cam_addr <= r_addr;
                                        r_cam_en   <= 1'b1;
                                    end
                                    T_ACT: begin
                                        r_act_data <= w_act_all[ACT_W-1:0];
                                        r_act_addr <= r_addr;
                                        r_act_en   <= 1'b1;
                                    end
                                    default: ;
                                endcase
                            end else begin
                                r_state   <= S_DROP;
                                r_err_cnt <= satInc(r_err_cnt);
                            end
                        end else begin
                            if (r_cnt == 2'd0) r_pay0 <= c_s_axis_tdata;
                            else               r_pay1 <= c_s_axis_tdata;
                            if (c_s_axis_tlast) begin
                                r_state   <= S_IDLE;
                                r_err_cnt <= satInc(r_err_cnt);
                            end else begin
                                r_cnt <= r_cnt + 2'd1;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    r_ok_cnt <= satInc(r_ok_cnt);
                    r_state  <= S_IDLE;
                end
                S_DROP: begin
                    if (w_accept && c_s_axis_tlast) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign key_off_entry_out   = r_koff_data;
    assign key_off_entry_addr  = r_koff_addr;
    assign key_off_entry_valid = r_koff_valid;
    assign lookup_din          = r_key;
    assign lookup_din_mask     = r_mask;
    assign lookup_din_addr     = r_cam_addr;
    assign lookup_din_en       = r_cam_en;
    assign action_data_out     = r_act_data;
    assign action_addr         = r_act_addr;
    assign action_en           = r_act_en;
    assign cfg_ok_cnt          = r_ok_cnt;
    assign cfg_err_cnt         = r_err_cnt;

endmodule
